// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU peripheral bus responder: control-register
// address map, control bit positions, end-of-program opcode, FSM states and
// the instruction layout.
package cpu_bus_pkg;

   localparam logic [8:0]  CTRL_ADDR       = 9'h1FF;
   localparam logic [8:0]  RSVD_ADDR       = 9'h1FE;
   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_IRQCLR_BIT = 1;
   localparam logic [7:0]  END_OPCODE      = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [55:0] payload;
   } instr_t;

endpackage

// File: rtl/instr_mem_2bank.sv
// Instruction memory built from two independently write-enabled 32-bit banks
// (low half / high half of each 64-bit instruction) with a registered read.
// Ports:
//   clk    - clock
//   we_lo  - write wdata into bits [31:0] of slot waddr
//   we_hi  - write wdata into bits [63:32] of slot waddr
//   waddr  - write slot
//   wdata  - write data (one half)
//   raddr  - read slot, sampled every clock
//   rdata  - {high, low} of slot raddr, one cycle after raddr
module instr_mem_2bank #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned HALF_W = 32
) (
   input  logic                  clk,
   input  logic                  we_lo,
   input  logic                  we_hi,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [HALF_W-1:0]     wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [2*HALF_W-1:0]   rdata
);

   logic [HALF_W-1:0] bank_lo [2**ADDR_W];
   logic [HALF_W-1:0] bank_hi [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_lo) bank_lo[waddr] <= wdata;
      if (we_hi) bank_hi[waddr] <= wdata;
      rdata <= {bank_hi[raddr], bank_lo[raddr]};
   end

endmodule

// File: rtl/cpu_instr_receiver.sv
// Responder end of the CPU peripheral bus. Bus writes fill a 256 x 64-bit
// instruction memory half by half; a START write to the control address runs
// the stored program, issuing instructions to the engine over valid/ready.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   CPU_instruction_valid   - one-cycle bus write strobe
//   CPU_instruction_addr    - bus write address (slot*2 + half, or control)
//   CPU_instruction_data    - bus write data
//   CPU_instruction_irq     - completion interrupt (level, cleared by CTRL)
//   instr_valid/instr_ready - issue handshake to the engine
//   instr_data              - issued instruction
//   engine_idle             - engine has no outstanding work
//   busy                    - program running (start until irq)
module cpu_instr_receiver
   import cpu_bus_pkg::*;
#(
   parameter int unsigned INSTR_NUM_BIT = 8,
   parameter int unsigned INSTR_W       = 64,
   parameter int unsigned BUS_W         = 32,
   parameter logic [7:0]  END_OPCODE    = cpu_bus_pkg::END_OPCODE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     CPU_instruction_valid,
   input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
   input  logic [BUS_W-1:0]         CPU_instruction_data,
   output logic                     CPU_instruction_irq,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [INSTR_W-1:0]       instr_data,
   input  logic                     engine_idle,
   output logic                     busy
);

   localparam int unsigned AW = INSTR_NUM_BIT + 1;
   // Highest usable program slot; the last slot's high half is the CTRL address.
   localparam logic [INSTR_NUM_BIT-1:0] LAST_PC = {{(INSTR_NUM_BIT-1){1'b1}}, 1'b0};

   state_t                   state;
   logic [INSTR_NUM_BIT-1:0] pc;
   logic [INSTR_NUM_BIT-1:0] rd_addr;
   logic [INSTR_W-1:0]       rdata;
   instr_t                   fetched;
   logic                     ctrl_wr;
   logic                     start;
   logic                     irq_clr;
   logic                     idle_like;
   logic                     mem_wr;
   logic                     handshake;
   logic                     last_slot;

   assign ctrl_wr   = CPU_instruction_valid && (CPU_instruction_addr == AW'(CTRL_ADDR));
   assign start     = ctrl_wr && CPU_instruction_data[CTRL_START_BIT];
   assign irq_clr   = ctrl_wr && CPU_instruction_data[CTRL_IRQCLR_BIT];
   assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
   assign mem_wr    = CPU_instruction_valid && idle_like &&
                      (CPU_instruction_addr < AW'(RSVD_ADDR));
   assign handshake = (state == ST_ISSUE) && instr_ready;
   assign last_slot = (pc == LAST_PC);
   assign fetched   = rdata;

   // Read address tracks the pc value the FSM is about to hold, so the
   // registered read data is already valid during the FETCH cycle.
   always_comb begin
      rd_addr = pc;
      if (idle_like && start) begin
         rd_addr = '0;
      end else if (handshake && !last_slot) begin
         rd_addr = pc + 1'b1;
      end
   end

   instr_mem_2bank #(
      .ADDR_W (INSTR_NUM_BIT),
      .HALF_W (BUS_W)
   ) u_mem (
      .clk   (clk),
      .we_lo (mem_wr && !CPU_instruction_addr[0]),
      .we_hi (mem_wr &&  CPU_instruction_addr[0]),
      .waddr (CPU_instruction_addr[AW-1:1]),
      .wdata (CPU_instruction_data),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= ST_IDLE;
         pc                  <= '0;
         CPU_instruction_irq <= 1'b0;
         instr_valid         <= 1'b0;
         busy                <= 1'b0;
         instr_data          <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  pc    <= '0;
                  busy  <= 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (fetched.opcode == END_OPCODE) begin
                  state <= ST_DRAIN;
               end else begin
                  instr_data  <= rdata;
                  instr_valid <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (last_slot) begin
                     state <= ST_DRAIN;
                  end else begin
                     pc    <= pc + 1'b1;
                     state <= ST_FETCH;
                  end
               end
            end
            ST_DRAIN: begin
               if (engine_idle) begin
                  CPU_instruction_irq <= 1'b1;
                  busy                <= 1'b0;
                  state               <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (start) begin
                  CPU_instruction_irq <= 1'b0;
                  pc                  <= '0;
                  busy                <= 1'b1;
                  state               <= ST_FETCH;
               end else if (irq_clr) begin
                  CPU_instruction_irq <= 1'b0;
                  state               <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_instr_receiver.sv
// Bench for cpu_instr_receiver: directed scenarios plus randomized programs,
// checked against a slot-array model of the program and the issued stream.
module tb_cpu_instr_receiver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        CPU_instruction_valid;
   logic [8:0]  CPU_instruction_addr;
   logic [31:0] CPU_instruction_data;
   logic        CPU_instruction_irq;
   logic        instr_valid;
   logic        instr_ready;
   logic [63:0] instr_data;
   logic        engine_idle;
   logic        busy;

   cpu_instr_receiver dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .CPU_instruction_valid (CPU_instruction_valid),
      .CPU_instruction_addr  (CPU_instruction_addr),
      .CPU_instruction_data  (CPU_instruction_data),
      .CPU_instruction_irq   (CPU_instruction_irq),
      .instr_valid           (instr_valid),
      .instr_ready           (instr_ready),
      .instr_data            (instr_data),
      .engine_idle           (engine_idle),
      .busy                  (busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] model_mem [256];
   logic [63:0] got_q [$];
   logic [63:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue monitor: captures handshakes and checks the hold rule during stalls.
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data  = '0;
   always @(negedge clk) begin
      if (prev_stall) begin
         chk("hold_valid", 64'(instr_valid), 64'd1);
         chk("hold_data", instr_data, prev_data);
      end
      prev_stall = rst_n && instr_valid && !instr_ready;
      prev_data  = instr_data;
      if (rst_n === 1'b1 && instr_valid && instr_ready) got_q.push_back(instr_data);
   end

   task automatic bus_wr(input logic [8:0] a, input logic [31:0] d, input bit to_model);
      CPU_instruction_valid = 1'b1;
      CPU_instruction_addr  = a;
      CPU_instruction_data  = d;
      @(posedge clk); #1;
      CPU_instruction_valid = 1'b0;
      if (to_model && a < 9'h1FE) begin
         if (a[0]) model_mem[a[8:1]][63:32] = d;
         else      model_mem[a[8:1]][31:0]  = d;
      end
   endtask

   task automatic write_slot(input int slot, input logic [63:0] v, input bit to_model);
      logic [7:0] s;
      s = 8'(slot);
      if ($urandom_range(0, 1) == 1) begin
         bus_wr({s, 1'b1}, v[63:32], to_model);
         bus_wr({s, 1'b0}, v[31:0], to_model);
      end else begin
         bus_wr({s, 1'b0}, v[31:0], to_model);
         bus_wr({s, 1'b1}, v[63:32], to_model);
      end
   endtask

   function automatic logic [63:0] rand_instr();
      logic [63:0] v;
      v = {$urandom, $urandom};
      v[63:56] = 8'($urandom_range(0, 254));
      return v;
   endfunction

   // Expected stream: slots in order from 0, stopping before the first END
   // opcode or after the last usable slot (254).
   function automatic void build_exp();
      exp_q.delete();
      for (int s = 0; s < 255; s++) begin
         if (model_mem[s][63:56] == 8'hFF) break;
         exp_q.push_back(model_mem[s]);
      end
   endfunction

   task automatic cmp_seq(input string tag);
      build_exp();
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_instr"}, got_q[i], exp_q[i]);
   endtask

   task automatic wait_irq(input string tag, input int max, input bit rnd);
      int n = 0;
      while (!CPU_instruction_irq && n < max) begin
         if (rnd) begin
            instr_ready = 1'($urandom_range(0, 1));
            engine_idle = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_irq"}, 64'(CPU_instruction_irq), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      CPU_instruction_valid = 1'b0;
      CPU_instruction_addr  = '0;
      CPU_instruction_data  = '0;
      instr_ready = 1'b0;
      engine_idle = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_irq", 64'(CPU_instruction_irq), 64'd0);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", instr_data, 64'd0);
      rst_n = 1'b1;

      // Basic two-slot program.
      bus_wr(9'h000, 32'h2, 1'b1);
      bus_wr(9'h001, 32'h1, 1'b1);
      bus_wr(9'h003, 32'hFF00_0000, 1'b1);
      bus_wr(9'h002, 32'h0, 1'b1);
      chk("model_slot0", model_mem[0], 64'h0000_0001_0000_0002);
      instr_ready = 1'b1;
      engine_idle = 1'b1;
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      chk("basic_busy_on", 64'(busy), 64'd1);
      wait_irq("basic", 50, 1'b0);
      cmp_seq("basic");

      // IRQ_CLEAR back to IDLE; reserved address must not act as START.
      bus_wr(9'h1FF, 32'h2, 1'b0);
      chk("clr_irq", 64'(CPU_instruction_irq), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      bus_wr(9'h1FE, 32'h1, 1'b0);
      chk("rsvd_nostart", 64'(busy), 64'd0);

      // Stall in ISSUE, then a slow-to-idle engine.
      instr_ready = 1'b0;
      engine_idle = 1'b0;
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      wait_valid("stall");
      repeat (10) begin @(posedge clk); #1; end
      chk("stall_valid_held", 64'(instr_valid), 64'd1);
      chk("stall_data", instr_data, 64'h0000_0001_0000_0002);
      instr_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_valid_drop", 64'(instr_valid), 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("drain_noirq", 64'(CPU_instruction_irq), 64'd0);
      end
      chk("drain_busy", 64'(busy), 64'd1);
      engine_idle = 1'b1;
      @(posedge clk); #1;
      chk("drain_irq", 64'(CPU_instruction_irq), 64'd1);
      cmp_seq("stall");

      // Clear then rerun: identical stream.
      bus_wr(9'h1FF, 32'h2, 1'b0);
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      wait_irq("rerun", 50, 1'b0);
      cmp_seq("rerun");

      // Writes while busy are dropped; START while busy is ignored.
      for (int s = 0; s < 5; s++) write_slot(s, rand_instr(), 1'b1);
      write_slot(5, {8'hFF, 56'($urandom)}, 1'b1);
      instr_ready = 1'b1;
      engine_idle = 1'b1;
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      instr_ready = 1'b0;
      write_slot(3, rand_instr(), 1'b0);
      bus_wr(9'h1FE, $urandom, 1'b0);
      bus_wr(9'h1FF, 32'h1, 1'b0);
      chk("busywr_busy", 64'(busy), 64'd1);
      wait_irq("busywr", 400, 1'b1);
      cmp_seq("busywr");

      // Reset mid-ISSUE aborts; program survives and restarts from slot 0.
      instr_ready = 1'b0;
      engine_idle = 1'b1;
      bus_wr(9'h1FF, 32'h3, 1'b0);
      wait_valid("abort");
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_valid", 64'(instr_valid), 64'd0);
      chk("abort_irq", 64'(CPU_instruction_irq), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_data", instr_data, 64'd0);
      rst_n = 1'b1;
      got_q.delete();
      instr_ready = 1'b1;
      bus_wr(9'h1FF, 32'h1, 1'b0);
      wait_irq("restart", 100, 1'b0);
      cmp_seq("restart");

      // Empty program: irq three cycles after the START write cycle.
      write_slot(0, {8'hFF, 56'($urandom)}, 1'b1);
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      chk("empty_irq_c1", 64'(CPU_instruction_irq), 64'd0);
      @(posedge clk); #1;
      chk("empty_irq_c2", 64'(CPU_instruction_irq), 64'd0);
      @(posedge clk); #1;
      chk("empty_irq_c3", 64'(CPU_instruction_irq), 64'd1);
      cmp_seq("empty");

      // Random programs with random handshake/idle behaviour.
      for (int it = 0; it < 6; it++) begin
         int len;
         len = $urandom_range(1, 10);
         for (int s = 0; s < len; s++) write_slot(s, rand_instr(), 1'b1);
         write_slot(len, {8'hFF, 56'($urandom)}, 1'b1);
         if ($urandom_range(0, 1) == 1) bus_wr(9'h1FF, 32'h2, 1'b0);
         got_q.delete();
         bus_wr(9'h1FF, ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1, 1'b0);
         wait_irq("rand", 400, 1'b1);
         cmp_seq("rand");
      end

      // Full memory with no END: implicit end after slot 254.
      for (int s = 0; s < 255; s++) write_slot(s, rand_instr(), 1'b1);
      got_q.delete();
      bus_wr(9'h1FF, 32'h1, 1'b0);
      wait_irq("full", 4000, 1'b1);
      cmp_seq("full");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_instr_receiver.md
Name: cpu_instr_receiver

Overview:
- Responder end of the CPU peripheral bus inside the accelerator.
- Accepts 32-bit bus writes and stores them as halves of 64-bit instructions in a 256-entry instruction memory.
- Decodes the control address (0x1FF) to start execution, then fetches and issues instructions to the compute engine over a valid/ready link.
- Raises CPU_instruction_irq once the program has ended and the engine is idle.

Parameters:
- INSTR_NUM_BIT, 8, log2 of instruction memory depth; bus address width is INSTR_NUM_BIT+1.
- INSTR_W, 64, instruction width.
- BUS_W, 32, CPU bus data width.
- END_OPCODE, 8'hFF, value of instr[63:56] that marks end of program.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- CPU_instruction_valid  in  1  one-cycle bus write strobe.
- CPU_instruction_addr  in  INSTR_NUM_BIT+1  bus write address.
- CPU_instruction_data  in  BUS_W  bus write data.
- CPU_instruction_irq  out  1  completion interrupt (level).
- instr_valid  out  1  issued instruction valid.
- instr_ready  in  1  engine accepts instruction.
- instr_data  out  INSTR_W  issued instruction.
- engine_idle  in  1  engine has no outstanding work.
- busy  out  1  high from start until irq asserts.

Behaviour:
- Reset (rst_n low at a clk edge): FSM to IDLE, pc=0; CPU_instruction_irq, instr_valid, busy = 0; instr_data = 0. Memory contents are not cleared.
- Address map, decoded on valid:
  - 0x000..0x1FD: slot = addr[8:1]; addr[0]=0 writes bits [31:0], addr[0]=1 writes bits [63:32]. Per-half write enable; no assembly state; halves may arrive in either order.
  - 0x1FE: reserved; write ignored.
  - 0x1FF: CTRL. data[0]=1 is START; data[1]=1 is IRQ_CLEAR. Usable program slots are 0..254.
- Memory writes take effect at the clk edge of the valid cycle.
- A memory write in any state other than IDLE/DONE is dropped.
- FSM states: IDLE, FETCH, ISSUE, DRAIN, DONE.
- IDLE: START -> FETCH with pc=0, busy=1. START and a memory write in the same cycle cannot occur because the addresses are exclusive.
- FETCH: synchronous read of mem[pc]; data is registered into instr_data next cycle.
  - If rdata[63:56]==END_OPCODE -> DRAIN; the END instruction is not issued.
  - Otherwise -> ISSUE with instr_valid=1.
- ISSUE: instr_valid and instr_data held stable until instr_ready=1.
  - On that handshake edge: instr_valid drops.
  - If pc==254 (implicit end) -> DRAIN; else pc++ and -> FETCH.
  - Throughput: one instruction per 2 cycles minimum.
- DRAIN: wait for engine_idle=1, sampled at least one cycle after the last handshake. Then -> DONE, CPU_instruction_irq=1, busy=0.
- DONE: irq held high.
  - IRQ_CLEAR -> irq=0, -> IDLE.
  - START -> irq=0, pc=0, -> FETCH. Write data 32'h3 counts as START.
- START while busy is ignored. IRQ_CLEAR outside DONE has no effect.
- Reset mid-operation aborts immediately: instr_valid drops the same edge and no irq is raised. The program remains in memory and can be restarted by START.
- An empty program (slot 0 is END) goes FETCH -> DRAIN -> DONE with no issue. Irq appears 3 cycles after the START write when engine_idle=1.

Decomposition:
- Package cpu_bus_pkg holds:
  - CTRL_ADDR = 9'h1FF, RSVD_ADDR = 9'h1FE
  - CTRL_START_BIT = 0, CTRL_IRQCLR_BIT = 1
  - END_OPCODE
  - the FSM state enum
  - instr_t typedef (64-bit, opcode [63:56])
- One sub-module, instr_mem_2bank: 256x64 memory with two 32-bit write-enabled banks and a 1-cycle registered read.
- The bus decode and FSM stay in the top.

Test Plan:
- Write slot0 = 64'h0000_0001_0000_0002 (addr 0x000 data 2, addr 0x001 data 1) and slot1 = END (addr 0x003 data 32'hFF00_0000). Then write addr 0x1FF data 1 with instr_ready=1 and engine_idle=1 -> exactly one issue with instr_data=64'h0000_0001_0000_0002, then irq=1 and busy=0.
- Hold instr_ready=0 for 10 cycles during ISSUE -> instr_valid stays 1 and instr_data stays stable. Release -> one handshake only and pc advances to 1.
- engine_idle=0 for 20 cycles after the last handshake -> irq stays 0. engine_idle=1 -> irq=1 the next edge.
- In DONE, write 0x1FF data 2 -> irq=0 and state IDLE. A second START reruns the same program with identical issue sequence.
- Write slot 3 while busy, write 0x1FE, and write START while busy -> memory unchanged, no restart, program completes normally.
- Deassert rst_n for one cycle mid-ISSUE -> next edge has instr_valid=0, irq=0, busy=0. A following START reissues from slot 0.
